hud_bcd_encoder: RTL
====================

Name: hud_bcd_encoder

Overview:
- Consumer side of the game counters: samples the score, timer, level and treasure counts once per frame.
- Converts each count to packed BCD digits for the HUD text renderer. The timer is shown as MM:SS.
- Uses a shared iterative shift-add-3 (double-dabble) engine, preceded by an iterative restoring divide-by-60 for the timer.
- Outputs hold stable between conversions, so the renderer can read them mid-frame.

Parameters:
- SCORE_W, 17, width of score input (6 BCD digits).
- TIME_W, 11, width of timer input in seconds.
- SECS_PER_MIN, 60, divisor used to split the timer into minutes and seconds.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  single-cycle request to sample and convert (one per frame).
- score_count  in  17  binary score.
- time_sec  in  11  remaining seconds.
- level  in  8  binary level.
- treasures  in  5  binary treasure count.
- busy  out  1  conversion in progress.
- digits_valid  out  1  one-cycle pulse when the BCD outputs have just been updated.
- score_bcd  out  24  six BCD digits, most-significant digit in [23:20].
- time_bcd  out  16  M1 M0 S1 S0, M1 in [15:12].
- level_bcd  out  12  three BCD digits.
- treasure_bcd  out  8  two BCD digits.

Behaviour:
- Reset (async assert, released synchronously by Clk):
  - FSM goes to IDLE.
  - All outputs go to 0: busy, digits_valid, and all *_bcd.
  - Internal latches and shift registers are cleared.
- IDLE: when frame_start=1 at a rising edge, latch all four inputs, go to DIV, and set busy=1 on that edge.
- DIV, 11 cycles (one quotient bit per cycle):
  - Restoring division of the latched time by SECS_PER_MIN.
  - Quotient gives minutes (6 bits, max 34). Remainder gives seconds (6 bits, 0..59).
- DD phases, each one iteration per cycle, each preloaded on entry:
  - DD_SCORE: 17 cycles.
  - DD_MIN: 6 cycles.
  - DD_SEC: 6 cycles.
  - DD_LVL: 8 cycles.
  - DD_TRS: 5 cycles.
- Shared double-dabble engine:
  - Each cycle: add 3 to every BCD nibble ≥5, then shift left by 1, bringing in the next binary MSB.
  - Each phase's result goes into a staging register, not the outputs.
  - The 6-digit score field is used in full (131071 max). Unused upper nibbles of the smaller fields read 0.
- Output update, on the edge that completes the last DD_TRS iteration:
  - All four *_bcd outputs load from staging simultaneously.
  - digits_valid=1 for exactly the following cycle.
  - busy=0 and FSM returns to IDLE.
- Latency: outputs update 54 edges after the edge that sampled frame_start (1 + 11 + 17 + 6 + 6 + 8 + 5). busy is high for those 54 cycles.
- frame_start while busy: ignored and not queued. Inputs changing during conversion do not affect the result.
- frame_start on the same edge that busy falls: ignored. A new request is accepted only from IDLE, so back-to-back conversions are 55 cycles apart minimum.
- Reset mid-conversion: abort immediately, with all outputs and state returned to reset values. No partial results are ever visible on *_bcd.
- Outputs are never partially updated; all four fields change on the same edge.

Test Plan:
- Reset, then score=114000, time=1200, level=0, treasures=0, pulse frame_start -> after 54 cycles: score_bcd=0x114000, time_bcd=0x2000, level_bcd=0x000, treasure_bcd=0x00, digits_valid high for exactly 1 cycle.
- time=0, then time=59, then time=2047 (separate frames) -> time_bcd=0x0000, 0x0059, 0x3407.
- score=131071, level=255, treasures=31 -> score_bcd=0x131071, level_bcd=0x255, treasure_bcd=0x31.
- Second frame_start 10 cycles after the first, with changed inputs -> ignored; outputs reflect the first inputs and only one digits_valid pulse occurs.
- Assert Reset at cycle 30 of a conversion -> all outputs 0 immediately, busy=0, and no digits_valid afterward; the next frame_start converts normally.
- Change score_count every cycle during busy -> result equals the value latched at frame_start.

Source files
------------

// File: rtl/hud_bcd_encoder.sv
// HUD counter encoder: samples score/timer/level/treasures once per frame and converts each
// to packed BCD with a shared double-dabble engine (timer first split into MM:SS by /60).
module hud_bcd_encoder #(
    parameter int unsigned SCORE_W      = 17,
    parameter int unsigned TIME_W       = 11,
    parameter int unsigned SECS_PER_MIN = 60
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_start,
    input  logic [SCORE_W-1:0] score_count,
    input  logic [TIME_W-1:0]  time_sec,
    input  logic [7:0]         level,
    input  logic [4:0]         treasures,
    output logic               busy,
    output logic               digits_valid,
    output logic [23:0]        score_bcd,
    output logic [15:0]        time_bcd,
    output logic [11:0]        level_bcd,
    output logic [7:0]         treasure_bcd
);

    typedef enum logic [2:0] {StIdle, StDiv, StScore, StMin, StSec, StLvl, StTrs} state_t;

    state_t             state;
    logic [4:0]         cnt;
    logic [SCORE_W-1:0] lat_score;
    logic [TIME_W-1:0]  lat_time;
    logic [7:0]         lat_level;
    logic [4:0]         lat_trs;
    logic [TIME_W-1:0]  dq;   // dividend shifts out the top, quotient shifts in the bottom
    logic [5:0]         rem;
    logic [SCORE_W-1:0] bin;
    logic [23:0]        bcd;
    logic [23:0]        stg_score;
    logic [7:0]         stg_min;
    logic [7:0]         stg_sec;
    logic [11:0]        stg_lvl;

    logic [6:0]           div_try;
    logic                 div_ge;
    logic [5:0]           rem_next;
    logic [TIME_W-1:0]    dq_next;
    logic [3:0]           nib;
    logic [23:0]          bcd_adj;
    logic [23+SCORE_W:0]  dd_next;
    logic [23:0]          bcd_next;
    logic [SCORE_W-1:0]   bin_next;

    always_comb begin
        div_try  = {rem, dq[TIME_W-1]};
        div_ge   = div_try >= 7'(SECS_PER_MIN);
        rem_next = div_ge ? 6'(div_try - 7'(SECS_PER_MIN)) : div_try[5:0];
        dq_next  = {dq[TIME_W-2:0], div_ge};

        nib     = '0;
        bcd_adj = '0;
        for (int i = 0; i < 6; i++) begin
            nib = bcd[4*i +: 4];
            bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        dd_next  = {bcd_adj, bin} << 1;
        bcd_next = dd_next[23+SCORE_W:SCORE_W];
        bin_next = dd_next[SCORE_W-1:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= StIdle;
            cnt          <= '0;
            lat_score    <= '0;
            lat_time     <= '0;
            lat_level    <= '0;
            lat_trs      <= '0;
            dq           <= '0;
            rem          <= '0;
            bin          <= '0;
            bcd          <= '0;
            stg_score    <= '0;
            stg_min      <= '0;
            stg_sec      <= '0;
            stg_lvl      <= '0;
            busy         <= 1'b0;
            digits_valid <= 1'b0;
            score_bcd    <= '0;
            time_bcd     <= '0;
            level_bcd    <= '0;
            treasure_bcd <= '0;
        end else begin
            digits_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (frame_start) begin
                        lat_score <= score_count;
                        lat_time  <= time_sec;
                        lat_level <= level;
                        lat_trs   <= treasures;
                        busy      <= 1'b1;
                        cnt       <= 5'd11;
                        state     <= StDiv;
                    end
                end
                StDiv: begin
                    // cnt==11 is the divider setup cycle, then 11 quotient bits
                    if (cnt == 5'd11) begin
                        dq  <= lat_time;
                        rem <= '0;
                        cnt <= 5'd10;
                    end else begin
                        dq  <= dq_next;
                        rem <= rem_next;
                        if (cnt == 5'd0) begin
                            bin   <= lat_score;
                            bcd   <= '0;
                            cnt   <= 5'(SCORE_W - 1);
                            state <= StScore;
                        end else begin
                            cnt <= cnt - 5'd1;
                        end
                    end
                end
                StScore, StMin, StSec, StLvl: begin
                    if (cnt == 5'd0) begin
                        bcd <= '0;
                        unique case (state)
                            StScore: begin
                                stg_score <= bcd_next;
                                bin       <= SCORE_W'(dq[5:0]) << (SCORE_W - 6);
                                cnt       <= 5'd5;
                                state     <= StMin;
                            end
                            StMin: begin
                                stg_min <= bcd_next[7:0];
                                bin     <= SCORE_W'(rem) << (SCORE_W - 6);
                                cnt     <= 5'd5;
                                state   <= StSec;
                            end
                            StSec: begin
                                stg_sec <= bcd_next[7:0];
                                bin     <= SCORE_W'(lat_level) << (SCORE_W - 8);
                                cnt     <= 5'd7;
                                state   <= StLvl;
                            end
                            default: begin
                                stg_lvl <= bcd_next[11:0];
                                bin     <= SCORE_W'(lat_trs) << (SCORE_W - 5);
                                cnt     <= 5'd4;
                                state   <= StTrs;
                            end
                        endcase
                    end else begin
                        bcd <= bcd_next;
                        bin <= bin_next;
                        cnt <= cnt - 5'd1;
                    end
                end
                StTrs: begin
                    if (cnt == 5'd0) begin
                        score_bcd    <= stg_score;
                        time_bcd     <= {stg_min, stg_sec};
                        level_bcd    <= stg_lvl;
                        treasure_bcd <= bcd_next[7:0];
                        digits_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= StIdle;
                    end else begin
                        bcd <= bcd_next;
                        bin <= bin_next;
                        cnt <= cnt - 5'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
